// File: rtl/game_sprite_mover_pkg.sv
// Shared screen, sprite and datapath dimensions for the sprite movers.
package game_sprite_mover_pkg;
  localparam int unsigned DEF_X_WIDTH       = 10;
  localparam int unsigned DEF_Y_WIDTH       = 10;
  localparam int unsigned DEF_D_WIDTH       = 3;
  localparam int unsigned DEF_SCREEN_W      = 640;
  localparam int unsigned DEF_SCREEN_H      = 480;
  localparam int unsigned DEF_SPRITE_W      = 8;
  localparam int unsigned DEF_SPRITE_H      = 8;
  localparam int unsigned DEF_UPDATE_PERIOD = 4;
endpackage

// File: rtl/game_sprite_step_timer.sv
// Enable-gated modulo-UPDATE_PERIOD counter; step is high on the wrap cycle.
module game_sprite_step_timer #(
  parameter int unsigned UPDATE_PERIOD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic step
);
  localparam int unsigned CW = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(UPDATE_PERIOD - 1);

  logic [CW-1:0] count;

  always_comb begin
    step = enable && !clear && (count == LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!enable || clear || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/game_sprite_mover.sv
// Position/velocity engine for one sprite, with on-screen flag and registered pixel hit.
module game_sprite_mover
  import game_sprite_mover_pkg::*;
#(
  parameter int unsigned X_WIDTH       = DEF_X_WIDTH,
  parameter int unsigned Y_WIDTH       = DEF_Y_WIDTH,
  parameter int unsigned D_WIDTH       = DEF_D_WIDTH,
  parameter int unsigned SCREEN_W      = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H      = DEF_SCREEN_H,
  parameter int unsigned SPRITE_W      = DEF_SPRITE_W,
  parameter int unsigned SPRITE_H      = DEF_SPRITE_H,
  parameter int unsigned UPDATE_PERIOD = DEF_UPDATE_PERIOD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sprite_write_xy,
  input  logic [X_WIDTH-1:0] sprite_write_x,
  input  logic [Y_WIDTH-1:0] sprite_write_y,
  input  logic               sprite_write_dxy,
  input  logic [D_WIDTH-1:0] sprite_write_dx,
  input  logic [D_WIDTH-1:0] sprite_write_dy,
  input  logic               sprite_enable_update,
  input  logic [X_WIDTH-1:0] pixel_x,
  input  logic [Y_WIDTH-1:0] pixel_y,
  output logic [X_WIDTH-1:0] sprite_x,
  output logic [Y_WIDTH-1:0] sprite_y,
  output logic               sprite_within_screen,
  output logic               sprite_hit
);
  localparam logic [X_WIDTH:0] X_MAX = (X_WIDTH+1)'(SCREEN_W - SPRITE_W);
  localparam logic [Y_WIDTH:0] Y_MAX = (Y_WIDTH+1)'(SCREEN_H - SPRITE_H);
  localparam logic [X_WIDTH:0] W_EXT = (X_WIDTH+1)'(SPRITE_W);
  localparam logic [Y_WIDTH:0] H_EXT = (Y_WIDTH+1)'(SPRITE_H);

  logic [D_WIDTH-1:0] dx, dy;
  logic               step;
  logic [X_WIDTH:0]   x_ext, px_ext;
  logic [Y_WIDTH:0]   y_ext, py_ext;
  logic               hit_next;

  game_sprite_step_timer #(.UPDATE_PERIOD(UPDATE_PERIOD)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (sprite_enable_update),
    .clear  (sprite_write_xy),
    .step   (step)
  );

  // One extra bit keeps pos+size from wrapping, so edge-of-range sprites never alias.
  always_comb begin
    x_ext    = {1'b0, sprite_x};
    y_ext    = {1'b0, sprite_y};
    px_ext   = {1'b0, pixel_x};
    py_ext   = {1'b0, pixel_y};
    hit_next = (px_ext >= x_ext) && (px_ext < x_ext + W_EXT) &&
               (py_ext >= y_ext) && (py_ext < y_ext + H_EXT);
    sprite_within_screen = (x_ext <= X_MAX) && (y_ext <= Y_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sprite_x   <= '0;
      sprite_y   <= '0;
      dx         <= '0;
      dy         <= '0;
      sprite_hit <= 1'b0;
    end else begin
      sprite_hit <= hit_next;
      if (sprite_write_xy) begin
        sprite_x <= sprite_write_x;
        sprite_y <= sprite_write_y;
      end else if (step) begin
        sprite_x <= sprite_x + {{(X_WIDTH-D_WIDTH){dx[D_WIDTH-1]}}, dx};
        sprite_y <= sprite_y + {{(Y_WIDTH-D_WIDTH){dy[D_WIDTH-1]}}, dy};
      end
      if (sprite_write_dxy) begin
        dx <= sprite_write_dx;
        dy <= sprite_write_dy;
      end
    end
  end
endmodule

// File: tb/tb_game_sprite_mover.sv
// Directed, table-driven bench for game_sprite_mover (640x480, 8x8, period 4).
module tb_game_sprite_mover;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sprite_write_xy = 1'b0;
  logic [9:0] sprite_write_x = '0;
  logic [9:0] sprite_write_y = '0;
  logic       sprite_write_dxy = 1'b0;
  logic [2:0] sprite_write_dx = '0;
  logic [2:0] sprite_write_dy = '0;
  logic       sprite_enable_update = 1'b0;
  logic [9:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic [9:0] sprite_x, sprite_y;
  logic       sprite_within_screen, sprite_hit;

  int n_vec = 0;
  int n_bad = 0;

  game_sprite_mover dut (
    .clk                  (clk),
    .reset                (reset),
    .sprite_write_xy      (sprite_write_xy),
    .sprite_write_x       (sprite_write_x),
    .sprite_write_y       (sprite_write_y),
    .sprite_write_dxy     (sprite_write_dxy),
    .sprite_write_dx      (sprite_write_dx),
    .sprite_write_dy      (sprite_write_dy),
    .sprite_enable_update (sprite_enable_update),
    .pixel_x              (pixel_x),
    .pixel_y              (pixel_y),
    .sprite_x             (sprite_x),
    .sprite_y             (sprite_y),
    .sprite_within_screen (sprite_within_screen),
    .sprite_hit           (sprite_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] x, y;
    logic [2:0] dx, dy;
    int         steps;
    logic [9:0] ex, ey;
    logic       ewithin;
  } move_vec_t;

  typedef struct {
    logic [9:0] sx, sy, px, py;
    logic       ehit;
  } hit_vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [9:0] x, input logic [9:0] y,
                      input logic [2:0] dx, input logic [2:0] dy);
    sprite_write_xy  = 1'b1;
    sprite_write_dxy = 1'b1;
    sprite_write_x   = x;
    sprite_write_y   = y;
    sprite_write_dx  = dx;
    sprite_write_dy  = dy;
    cycle();
    sprite_write_xy  = 1'b0;
    sprite_write_dxy = 1'b0;
  endtask

  task automatic check_pos(input string name, input int ex, input int ey);
    check({name, ".x"}, int'(sprite_x), ex);
    check({name, ".y"}, int'(sprite_y), ey);
  endtask

  move_vec_t mv[8];
  hit_vec_t  hv[8];

  initial begin
    mv[0] = '{10'd100, 10'd50,   3'b010, 3'b111, 2, 10'd104,  10'd48,  1'b1};
    mv[1] = '{10'd631, 10'd10,   3'b001, 3'b000, 1, 10'd632,  10'd10,  1'b1};
    mv[2] = '{10'd631, 10'd10,   3'b001, 3'b000, 2, 10'd633,  10'd10,  1'b0};
    mv[3] = '{10'd0,   10'd0,    3'b111, 3'b000, 1, 10'd1023, 10'd0,   1'b0};
    mv[4] = '{10'd10,  10'd20,   3'b100, 3'b011, 3, 10'd1022, 10'd29,  1'b0};
    mv[5] = '{10'd300, 10'd470,  3'b000, 3'b001, 2, 10'd300,  10'd472, 1'b1};
    mv[6] = '{10'd300, 10'd470,  3'b000, 3'b001, 3, 10'd300,  10'd473, 1'b0};
    mv[7] = '{10'd1023,10'd1023, 3'b001, 3'b001, 1, 10'd0,    10'd0,   1'b1};

    hv[0] = '{10'd20,   10'd30, 10'd20,   10'd30, 1'b1};
    hv[1] = '{10'd20,   10'd30, 10'd27,   10'd37, 1'b1};
    hv[2] = '{10'd20,   10'd30, 10'd28,   10'd30, 1'b0};
    hv[3] = '{10'd20,   10'd30, 10'd19,   10'd30, 1'b0};
    hv[4] = '{10'd20,   10'd30, 10'd20,   10'd38, 1'b0};
    hv[5] = '{10'd20,   10'd30, 10'd27,   10'd29, 1'b0};
    hv[6] = '{10'd1020, 10'd0,  10'd2,    10'd0,  1'b0};
    hv[7] = '{10'd1020, 10'd0,  10'd1023, 10'd7,  1'b1};

    @(negedge clk);
    check_pos("reset", 0, 0);
    check("reset.within", int'(sprite_within_screen), 1);
    check("reset.hit", int'(sprite_hit), 0);
    cycle();
    reset = 1'b0;
    cycle();

    foreach (mv[i]) begin
      load(mv[i].x, mv[i].y, mv[i].dx, mv[i].dy);
      sprite_enable_update = 1'b1;
      repeat (mv[i].steps * 4) cycle();
      sprite_enable_update = 1'b0;
      check_pos($sformatf("move%0d", i), int'(mv[i].ex), int'(mv[i].ey));
      check($sformatf("move%0d.within", i), int'(sprite_within_screen), int'(mv[i].ewithin));
    end

    foreach (hv[i]) begin
      load(hv[i].sx, hv[i].sy, 3'b000, 3'b000);
      pixel_x = hv[i].px;
      pixel_y = hv[i].py;
      cycle();
      check($sformatf("hit%0d", i), int'(sprite_hit), int'(hv[i].ehit));
    end

    // Hit latency: a newly inside pixel is not reflected until the next edge.
    load(10'd20, 10'd30, 3'b000, 3'b000);
    pixel_x = 10'd19; pixel_y = 10'd30;
    cycle();
    pixel_x = 10'd20;
    #1 check("hit_latency.old", int'(sprite_hit), 0);
    cycle();
    check("hit_latency.new", int'(sprite_hit), 1);

    // Step timing: steps land after the 4th and 8th enabled edges.
    load(10'd100, 10'd50, 3'b010, 3'b111);
    sprite_enable_update = 1'b1;
    repeat (3) cycle();
    check_pos("t1.c3", 100, 50);
    cycle();
    check_pos("t1.c4", 102, 49);
    repeat (3) cycle();
    check_pos("t1.c7", 102, 49);
    cycle();
    check_pos("t1.c8", 104, 48);
    check("t1.within", int'(sprite_within_screen), 1);
    sprite_enable_update = 1'b0;

    // write_xy on a due step wins and restarts the period; write_dxy on a step uses old dx.
    load(10'd50, 10'd50, 3'b001, 3'b000);
    sprite_enable_update = 1'b1;
    repeat (3) cycle();
    sprite_write_xy = 1'b1; sprite_write_x = 10'd5; sprite_write_y = 10'd5;
    cycle();
    sprite_write_xy = 1'b0;
    check_pos("t4.wxy", 5, 5);
    repeat (3) cycle();
    check_pos("t4.c3", 5, 5);
    cycle();
    check_pos("t4.c4", 6, 5);
    repeat (3) cycle();
    sprite_write_dxy = 1'b1; sprite_write_dx = 3'b011; sprite_write_dy = 3'b000;
    cycle();
    sprite_write_dxy = 1'b0;
    check_pos("t4.olddx", 7, 5);
    repeat (4) cycle();
    check_pos("t4.newdx", 10, 5);
    sprite_enable_update = 1'b0;

    // Enable pause clears the counter and freezes position.
    load(10'd200, 10'd100, 3'b001, 3'b001);
    sprite_enable_update = 1'b1;
    repeat (2) cycle();
    sprite_enable_update = 1'b0;
    repeat (2) cycle();
    check_pos("t5.paused", 200, 100);
    sprite_enable_update = 1'b1;
    repeat (3) cycle();
    check_pos("t5.c3", 200, 100);
    cycle();
    check_pos("t5.c4", 201, 101);

    // Asynchronous reset mid-run.
    load(10'd700, 10'd100, 3'b001, 3'b001);
    pixel_x = 10'd701; pixel_y = 10'd101;
    repeat (2) cycle();
    check("t6.prehit", int'(sprite_hit), 1);
    check("t6.prewithin", int'(sprite_within_screen), 0);
    reset = 1'b1;
    #1;
    check_pos("t6.rst", 0, 0);
    check("t6.rst.hit", int'(sprite_hit), 0);
    check("t6.rst.within", int'(sprite_within_screen), 1);
    cycle();
    reset = 1'b0;
    pixel_x = 10'd500;
    repeat (4) cycle();
    check_pos("t6.dx0", 0, 0);
    sprite_enable_update = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
